bus_interface_unit: RTL
=======================

# bus_interface_unit

Bus interface unit between the V68k execution core and the 68000 external bus pins. The core hands it one read or write request (byte, word or long) over a valid/ready handshake. The unit runs the asynchronous AS/UDS/LDS/DTACK bus cycle, splitting longs into two word cycles, and returns read data or an error on a one-cycle response strobe. It replaces the core's inline fetch/strobe sequencing.

## Interface
Parameters:
- TIMEOUT, default 255: WAIT cycles without DTACK before a bus error is forced (8-bit counter).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE; transfer happens on req_valid & req_ready.
- req_addr  in  24  byte address.
- req_rw  in  1  1 = read, 0 = write.
- req_size  in  2  00 byte, 01 word, 10 long, 11 reserved.
- req_wdata  in  32  write data: byte in [7:0], word in [15:0], long in [31:0].
- req_fc  in  3  function code for the cycle.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data, zero-extended; 0 on any error or write.
- rsp_berr  out  1  bus error (BERR or timeout); valid with rsp_valid.
- rsp_addr_err  out  1  odd-address word/long or reserved size; valid with rsp_valid.
- A  out  23  address bits [23:1].
- AS, UDS, LDS  out  1 each  active-low strobes.
- RW  out  1  1 read, 0 write.
- FC  out  3  function code.
- D_in  in  16  data bus input.
- D_out  out  16  data bus drive value.
- D_oe  out  1  data bus output enable (write only).
- DTACK, BERR  in  1 each  active-high terminations.

## Operation
- Reset values: A=0, AS=UDS=LDS=1, RW=1, FC=0, D_out=0, D_oe=0, rsp_valid=0, rsp_rdata=0, rsp_berr=0, rsp_addr_err=0. State is IDLE, so req_ready=1.
- States: IDLE, ADDR, ASTB, DSTB (write only), WAIT, TERM, AERR.
- IDLE: on accept, latch the request.
  - Word/long with addr[0]=1, or size 11: go to AERR.
  - Otherwise go to ADDR.
- AERR: rsp_valid=1, rsp_addr_err=1; no strobe ever asserts; then IDLE.
- ADDR: drive A, RW, FC with strobes negated. Writes: D_oe=1 and D_out loaded.
- ASTB: AS=0.
  - Reads: lane strobes asserted in the same cycle, then go to WAIT.
  - Writes: go to DSTB, which asserts the lane strobes and then goes to WAIT.
- Lane strobes:
  - Byte at even address: UDS only.
  - Byte at odd address: LDS only.
  - Word/long: both.
- Write data on D_out:
  - Byte: {b,b}.
  - Word: wdata[15:0].
  - Long: wdata[31:16] first, then [15:0].
- WAIT: sample DTACK/BERR each cycle; the counter clears on entry.
  - BERR=1 (wins over a simultaneous DTACK): error.
  - Else DTACK=1: latch D_in and go to TERM.
  - Else counter==TIMEOUT-1: error.
- TERM: AS/UDS/LDS=1, D_oe=0.
  - If long, first word, and no error: go to ADDR with A+1 (next word).
  - Otherwise: rsp_valid=1 and go to IDLE.
- Read data assembly:
  - Byte: lane byte into [7:0].
  - Word: D_in into [15:0].
  - Long: first word into [31:16], second into [15:0].
- An error on the first word of a long aborts the second; the response carries berr=1 and rdata=0.
- RESET at any point: strobes negated and D_oe=0 on the next edge; the response is dropped and the state returns to IDLE.

## Timing
- Cycle 0 is the accept cycle; strobes are registered outputs.
- Zero-wait read word: ADDR c1, ASTB c2 (AS/DS low), WAIT c3, TERM c4 (rsp_valid, strobes high), IDLE c5.
- Zero-wait write: adds DSTB, so TERM is at c5.
- Each WAIT cycle with DTACK=0 adds one cycle.
- Long: the second ADDR follows the first TERM directly. A zero-wait long read completes at c8.
- Address error: rsp_valid at c1.
- No new request is accepted before the IDLE cycle following TERM/AERR.
- AS is low through the whole of ASTB..WAIT.
- Write: D_oe is high from ADDR to WAIT inclusive, and D_out is stable from ADDR onward.

## Test plan
- Read word 0x001000, DTACK tied 1, D_in=0xBEEF -> AS low c2-c3, UDS=LDS=0, rsp_valid c4, rdata=0x0000BEEF.
- Write byte 0x000003 with 0x5A, DTACK after 2 wait cycles -> LDS only, UDS=1, D_out=0x5A5A, RW=0, rsp_valid c7.
- Read long 0x000100, D_in 0x1234 then 0x5678 -> A=0x80 then 0x81, rdata=0x12345678, rsp_valid c8.
- Word read at 0x000101 -> rsp_valid c1, rsp_addr_err=1; AS never low.
- DTACK held 0, TIMEOUT=4 -> rsp_berr=1, rdata=0, strobes negated in TERM. Separately, BERR and DTACK together in WAIT -> berr=1.
- RESET asserted during WAIT of a write -> next cycle AS=UDS=LDS=1, D_oe=0, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/bus_interface_unit.sv
// Bus interface unit: turns one core byte/word/long request into 68000-style
// AS/UDS/LDS/DTACK bus cycles and returns a single-cycle response.
module bus_interface_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   input  logic        req_rw,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_fc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_berr,
   output logic        rsp_addr_err,
   output logic [22:0] A,
   output logic        AS,
   output logic        UDS,
   output logic        LDS,
   output logic        RW,
   output logic [2:0]  FC,
   input  logic [15:0] D_in,
   output logic [15:0] D_out,
   output logic        D_oe,
   input  logic        DTACK,
   input  logic        BERR
);

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 16;
   localparam int unsigned RW_W = 32;
   localparam int unsigned CW = 8;
   localparam int unsigned FW = 3;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_WORD = 2'b01;
   localparam logic [1:0] SZ_LONG = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ASTB,
      S_DSTB,
      S_WAIT,
      S_TERM,
      S_AERR
   } state_e;

   state_e state_q, state_d;

   // Latched request context
   logic [1:0]      size_q, size_d;
   logic            rd_q, rd_d;
   logic            odd_q, odd_d;
   logic [DW-1:0]   wlo_q, wlo_d;
   logic            second_q, second_d;
   logic            more_q, more_d;
   logic [DW-1:0]   hi_q, hi_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Registered bus and response outputs
   logic [AW-2:0]   a_q, a_d;
   logic            as_q, as_d;
   logic            uds_q, uds_d;
   logic            lds_q, lds_d;
   logic            rw_q, rw_d;
   logic [FW-1:0]   fc_q, fc_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            doe_q, doe_d;
   logic            rdy_q, rdy_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [RW_W-1:0] rdata_q, rdata_d;
   logic            berr_q, berr_d;
   logic            aerr_q, aerr_d;

   logic [1:0]      lanes_n;

   // Active-low {UDS, LDS} for a size/alignment: bytes pick one lane, words/longs both.
   function automatic logic [1:0] lane_strobes(input logic [1:0] size, input logic odd);
      logic [1:0] s;
      s = 2'b00;
      if (size == SZ_BYTE) s = odd ? 2'b10 : 2'b01;
      return s;
   endfunction

   // First data-bus word of a write; a long sends its high half first.
   function automatic logic [DW-1:0] first_word(input logic [1:0] size, input logic [RW_W-1:0] wd);
      logic [DW-1:0] w;
      case (size)
         SZ_BYTE: w = {wd[7:0], wd[7:0]};
         SZ_LONG: w = wd[31:16];
         default: w = wd[15:0];
      endcase
      return w;
   endfunction

   // Read data assembled from the word just terminated.
   function automatic logic [RW_W-1:0] read_data(input logic [1:0] size, input logic odd,
                                                 input logic [DW-1:0] hi, input logic [DW-1:0] d);
      logic [RW_W-1:0] r;
      case (size)
         SZ_BYTE: r = {24'h0, (odd ? d[7:0] : d[15:8])};
         SZ_LONG: r = {hi, d};
         default: r = {16'h0, d};
      endcase
      return r;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         size_q      <= SZ_BYTE;
         rd_q        <= 1'b1;
         odd_q       <= 1'b0;
         wlo_q       <= '0;
         second_q    <= 1'b0;
         more_q      <= 1'b0;
         hi_q        <= '0;
         cnt_q       <= '0;
         a_q         <= '0;
         as_q        <= 1'b1;
         uds_q       <= 1'b1;
         lds_q       <= 1'b1;
         rw_q        <= 1'b1;
         fc_q        <= '0;
         dout_q      <= '0;
         doe_q       <= 1'b0;
         rdy_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         berr_q      <= 1'b0;
         aerr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         rd_q        <= rd_d;
         odd_q       <= odd_d;
         wlo_q       <= wlo_d;
         second_q    <= second_d;
         more_q      <= more_d;
         hi_q        <= hi_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         as_q        <= as_d;
         uds_q       <= uds_d;
         lds_q       <= lds_d;
         rw_q        <= rw_d;
         fc_q        <= fc_d;
         dout_q      <= dout_d;
         doe_q       <= doe_d;
         rdy_q       <= rdy_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         berr_q      <= berr_d;
         aerr_q      <= aerr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      rd_d        = rd_q;
      odd_d       = odd_q;
      wlo_d       = wlo_q;
      second_d    = second_q;
      more_d      = more_q;
      hi_d        = hi_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      as_d        = as_q;
      uds_d       = uds_q;
      lds_d       = lds_q;
      rw_d        = rw_q;
      fc_d        = fc_q;
      dout_d      = dout_q;
      doe_d       = doe_q;
      rdy_d       = rdy_q;
      rsp_valid_d = 1'b0;
      rdata_d     = '0;
      berr_d      = 1'b0;
      aerr_d      = 1'b0;
      lanes_n     = lane_strobes(size_q, odd_q);

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               size_d   = req_size;
               rd_d     = req_rw;
               odd_d    = req_addr[0];
               wlo_d    = req_wdata[15:0];
               second_d = 1'b0;
               more_d   = 1'b0;
               hi_d     = '0;
               rdy_d    = 1'b0;
               if (req_size == SZ_RSVD || (req_size != SZ_BYTE && req_addr[0])) begin
                  state_d     = S_AERR;
                  rsp_valid_d = 1'b1;
                  aerr_d      = 1'b1;
               end else begin
                  state_d = S_ADDR;
                  a_d     = req_addr[AW-1:1];
                  rw_d    = req_rw;
                  fc_d    = req_fc;
                  doe_d   = ~req_rw;
                  if (!req_rw) dout_d = first_word(req_size, req_wdata);
               end
            end
         end
         S_AERR: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end
         S_ADDR: begin
            state_d = S_ASTB;
            as_d    = 1'b0;
            if (rd_q) {uds_d, lds_d} = lanes_n;
         end
         // Writes hold the lane strobes back one cycle so data is settled first
         S_ASTB: begin
            cnt_d = '0;
            if (rd_q) begin
               state_d = S_WAIT;
            end else begin
               state_d        = S_DSTB;
               {uds_d, lds_d} = lanes_n;
            end
         end
         S_DSTB: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         // BERR beats DTACK, DTACK beats the timeout
         S_WAIT: begin
            if (BERR || (!DTACK && cnt_q == CNT_LAST)) begin
               state_d     = S_TERM;
               {as_d, uds_d, lds_d} = 3'b111;
               doe_d       = 1'b0;
               more_d      = 1'b0;
               rsp_valid_d = 1'b1;
               berr_d      = 1'b1;
            end else if (DTACK) begin
               state_d = S_TERM;
               {as_d, uds_d, lds_d} = 3'b111;
               doe_d   = 1'b0;
               if (size_q == SZ_LONG && !second_q) begin
                  more_d = 1'b1;
                  hi_d   = D_in;
               end else begin
                  rsp_valid_d = 1'b1;
                  if (rd_q) rdata_d = read_data(size_q, odd_q, hi_q, D_in);
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_TERM: begin
            if (more_q) begin
               state_d  = S_ADDR;
               second_d = 1'b1;
               more_d   = 1'b0;
               a_d      = a_q + 23'd1;
               doe_d    = ~rd_q;
               if (!rd_q) dout_d = wlo_q;
            end else begin
               state_d = S_IDLE;
               rdy_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            rdy_d   = 1'b1;
         end
      endcase
   end

   assign req_ready    = rdy_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign rsp_berr     = berr_q;
   assign rsp_addr_err = aerr_q;
   assign A            = a_q;
   assign AS           = as_q;
   assign UDS          = uds_q;
   assign LDS          = lds_q;
   assign RW           = rw_q;
   assign FC           = fc_q;
   assign D_out        = dout_q;
   assign D_oe         = doe_q;

endmodule
